counter_updown_mod: RTL and testbench

Parametrised successor to the basic enabled binary counter. Up/down counter with a runtime modulus, parallel load, programmable prescaler, and wrap or saturate mode. Outputs a terminal-event pulse and a sticky overflow flag. Used as a general timebase and event counter in later lab designs: blink dividers, PWM periods, and bounded indexes.

---
 rtl/counter_updown_mod.sv | 96 +++++++++
 tb/tb_counter_updown_mod.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_mod.sv
// Up/down counter with runtime modulus, parallel load, prescaler and wrap/saturate boundary mode.
// Emits a one-cycle tick and a sticky ovf flag on every boundary event.
module counter_updown_mod #(
   parameter int N          = 8,
   parameter int PRESCALE_W = 4,
   parameter int SATURATE   = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  up_down,
   input  logic                  load,
   input  logic [N-1:0]          load_val,
   input  logic [N-1:0]          max_val,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  clr_ovf,
   output logic [N-1:0]          counter,
   output logic                  tick,
   output logic                  ovf
);

   localparam bit SAT = (SATURATE != 0);

   logic [PRESCALE_W-1:0] pre_cnt;
   logic [PRESCALE_W-1:0] pre_nxt;
   logic                  step;
   logic [N-1:0]          cnt_nxt;
   logic                  bound_evt;
   logic [N-1:0]          load_clamped;

   // >= rather than == so a prescale lowered below pre_cnt still qualifies a step
   always_comb begin
      step    = 1'b0;
      pre_nxt = pre_cnt;
      if (enable) begin
         if (pre_cnt >= prescale) begin
            step    = 1'b1;
            pre_nxt = '0;
         end else begin
            pre_nxt = pre_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      cnt_nxt   = counter;
      bound_evt = 1'b0;
      if (step) begin
         if (up_down) begin
            if (counter < max_val) begin
               cnt_nxt = counter + 1'b1;
            end else begin
               bound_evt = 1'b1;
               cnt_nxt   = SAT ? max_val : '0;
            end
         end else begin
            if (counter > max_val) begin
               cnt_nxt = max_val;
            end else if (counter != '0) begin
               cnt_nxt = counter - 1'b1;
            end else begin
               bound_evt = 1'b1;
               cnt_nxt   = SAT ? '0 : max_val;
            end
         end
      end
   end

   assign load_clamped = (load_val > max_val) ? max_val : load_val;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter <= '0;
         pre_cnt <= '0;
         tick    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         if (load) begin
            counter <= load_clamped;
            pre_cnt <= '0;
            tick    <= 1'b0;
         end else begin
            counter <= cnt_nxt;
            pre_cnt <= pre_nxt;
            tick    <= bound_evt;
         end
         // set wins over clear; a load cycle never produces an event
         if (bound_evt && !load) begin
            ovf <= 1'b1;
         end else if (clr_ovf) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: wrap and saturate instances share stimulus;
// a per-cycle scoreboard plus directed checks of the boundary scenarios.
module tb_counter_updown_mod;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       up_down;
   logic       load;
   logic [7:0] load_val;
   logic [7:0] max_val;
   logic [3:0] prescale;
   logic       clr_ovf;
   logic [7:0] cnt_w, cnt_s;
   logic       tick_w, tick_s, ovf_w, ovf_s;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] c0, c1;
      logic       t0, t1, o0, o1;
   } exp_t;
   exp_t sb[$];

   int m_cnt[2];
   int m_tick[2];
   int m_ovf[2];
   int m_pre;

   always #5 clk = ~clk;

   counter_updown_mod #(.N(8), .PRESCALE_W(4), .SATURATE(0)) dut_w (
      .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
      .load_val(load_val), .max_val(max_val), .prescale(prescale), .clr_ovf(clr_ovf),
      .counter(cnt_w), .tick(tick_w), .ovf(ovf_w));

   counter_updown_mod #(.N(8), .PRESCALE_W(4), .SATURATE(1)) dut_s (
      .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
      .load_val(load_val), .max_val(max_val), .prescale(prescale), .clr_ovf(clr_ovf),
      .counter(cnt_s), .tick(tick_s), .ovf(ovf_s));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_tick[i] = 0; m_ovf[i] = 0;
      end
      m_pre = 0;
   endtask

   task automatic model_update();
      int nxt_pre;
      bit q;
      int c, mx, ev;
      q = 0;
      nxt_pre = m_pre;
      if (load) nxt_pre = 0;
      else if (enable) begin
         if (m_pre >= int'(prescale)) begin q = 1; nxt_pre = 0; end
         else nxt_pre = m_pre + 1;
      end
      for (int i = 0; i < 2; i++) begin
         c = m_cnt[i]; mx = int'(max_val); ev = 0;
         if (load) c = (int'(load_val) > mx) ? mx : int'(load_val);
         else if (q) begin
            if (up_down) begin
               if (c < mx) c = c + 1;
               else begin ev = 1; c = (i == 1) ? mx : 0; end
            end else begin
               if (c > mx) c = mx;
               else if (c > 0) c = c - 1;
               else begin ev = 1; c = (i == 1) ? 0 : mx; end
            end
         end
         m_cnt[i] = c;
         m_tick[i] = ev;
         if (ev == 1) m_ovf[i] = 1;
         else if (clr_ovf) m_ovf[i] = 0;
      end
      m_pre = nxt_pre;
   endtask

   // one clock: model the edge, push expectation, let the edge happen, compare
   task automatic cyc();
      exp_t e;
      model_update();
      e.c0 = 8'(m_cnt[0]); e.c1 = 8'(m_cnt[1]);
      e.t0 = 1'(m_tick[0]); e.t1 = 1'(m_tick[1]);
      e.o0 = 1'(m_ovf[0]); e.o1 = 1'(m_ovf[1]);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("sb_cnt_w", 32'(cnt_w), 32'(e.c0));
      chk("sb_cnt_s", 32'(cnt_s), 32'(e.c1));
      chk("sb_tick_w", 32'(tick_w), 32'(e.t0));
      chk("sb_tick_s", 32'(tick_s), 32'(e.t1));
      chk("sb_ovf_w", 32'(ovf_w), 32'(e.o0));
      chk("sb_ovf_s", 32'(ovf_s), 32'(e.o1));
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; load_val = '0;
      max_val = 8'd255; prescale = '0; clr_ovf = 1'b0;
      model_reset();
      #3;
      chk("rst_cnt", 32'(cnt_w), 32'd0);
      chk("rst_tick", 32'(tick_w), 32'd0);
      chk("rst_ovf", 32'(ovf_s), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // 1: asynchronous reset mid-count
      enable = 1'b1;
      cycles(37);
      chk("t1_cnt37", 32'(cnt_w), 32'd37);
      #2 reset = 1'b1;
      #1;
      chk("t1_async_cnt", 32'(cnt_w), 32'd0);
      chk("t1_async_tick", 32'(tick_w), 32'd0);
      chk("t1_async_ovf", 32'(ovf_w), 32'd0);
      chk("t1_async_cnt_s", 32'(cnt_s), 32'd0);
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;

      // 2: wrap at max_val=9, then clear ovf
      max_val = 8'd9;
      cycles(9);
      chk("t2_cnt9", 32'(cnt_w), 32'd9);
      chk("t2_tick_pre", 32'(tick_w), 32'd0);
      cyc();
      chk("t2_wrap_cnt", 32'(cnt_w), 32'd0);
      chk("t2_wrap_tick", 32'(tick_w), 32'd1);
      chk("t2_wrap_ovf", 32'(ovf_w), 32'd1);
      cyc();
      chk("t2_tick_once", 32'(tick_w), 32'd0);
      enable = 1'b0; clr_ovf = 1'b1;
      cyc();
      chk("t2_clr_ovf", 32'(ovf_w), 32'd0);
      clr_ovf = 1'b0;

      // 3: prescale=3
      max_val = 8'd255; load = 1'b1; load_val = 8'd0;
      cyc();
      load = 1'b0; prescale = 4'd3; enable = 1'b1;
      cycles(12);
      chk("t3_cnt3", 32'(cnt_w), 32'd3);
      enable = 1'b0;
      cycles(5);
      chk("t3_hold", 32'(cnt_w), 32'd3);
      enable = 1'b1;
      cycles(3);
      chk("t3_no_early", 32'(cnt_w), 32'd3);
      cyc();
      chk("t3_step4", 32'(cnt_w), 32'd4);

      // 4: saturate down from 2
      prescale = 4'd0; load = 1'b1; load_val = 8'd2; up_down = 1'b0;
      cyc();
      load = 1'b0;
      cyc();
      chk("t4_s1", 32'(cnt_s), 32'd1);
      chk("t4_s1_tick", 32'(tick_s), 32'd0);
      cyc();
      chk("t4_s0", 32'(cnt_s), 32'd0);
      chk("t4_s0_tick", 32'(tick_s), 32'd0);
      cyc();
      chk("t4_hold0", 32'(cnt_s), 32'd0);
      chk("t4_hold0_tick", 32'(tick_s), 32'd1);
      cyc();
      chk("t4_hold0b_tick", 32'(tick_s), 32'd1);
      chk("t4_ovf", 32'(ovf_s), 32'd1);

      // 5: load clamps, then down with lowered max_val
      load = 1'b1; load_val = 8'd200; max_val = 8'd150; up_down = 1'b1;
      cyc();
      chk("t5_clamp", 32'(cnt_w), 32'd150);
      chk("t5_tick", 32'(tick_w), 32'd0);
      load = 1'b0; max_val = 8'd100; up_down = 1'b0;
      cyc();
      chk("t5_lower", 32'(cnt_w), 32'd100);
      chk("t5_lower_tick", 32'(tick_w), 32'd0);

      // 6: clr_ovf coincident with wrap
      max_val = 8'd3; load = 1'b1; load_val = 8'd3; up_down = 1'b1;
      cyc();
      load = 1'b0; clr_ovf = 1'b1;
      cyc();
      chk("t6_cnt", 32'(cnt_w), 32'd0);
      chk("t6_tick", 32'(tick_w), 32'd1);
      chk("t6_ovf_set_wins", 32'(ovf_w), 32'd1);
      enable = 1'b0;
      cyc();
      chk("t6_ovf_cleared", 32'(ovf_w), 32'd0);
      clr_ovf = 1'b0;

      // randomised tail against the scoreboard, incl. runtime prescale/max_val changes
      for (int k = 0; k < 300; k++) begin
         enable   = ($urandom_range(0, 3) != 0);
         up_down  = 1'($urandom_range(0, 1));
         load     = ($urandom_range(0, 15) == 0);
         load_val = 8'($urandom_range(0, 255));
         clr_ovf  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 7) == 0) max_val = 8'($urandom_range(0, 12));
         if ($urandom_range(0, 9) == 0) prescale = 4'($urandom_range(0, 3));
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
